code_sender: RTL

//  Transmit side of the Start/Red/Green/Blue code-entry interface: serialises a
//  NUM_SYMS x 3-bit code into Start + one RGB symbol per cycle, samples the

---
 rtl/code_sender.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/code_sender.sv
// code_sender: transmit side of the Start/Red/Green/Blue code-entry link.
// Serialises a NUM_SYMS x 3-bit code as one header cycle, one RGB symbol per
// cycle and one check cycle. It samples the detector's U flag on the edge that
// leaves the check cycle, then inserts GAP_CYCLES idle-start cycles.
// Optional build macro: SWEEP_EN. When it is defined, the block gains a brute-force
// sweep over every code, with Sweep / Found / Found_code ports.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for Send (or Sweep); Start=0, RGB=000, Busy=0
// S_HDR   | header cycle; Start=1, RGB=000
// S_SYM   | one symbol per cycle, symbol 0 first; Start=1
// S_CHECK | detector settles; U sampled into Match on the exit edge
// S_GAP   | Start=0 spacer; Done pulses in the first cycle only
module code_sender #(
  parameter int NUM_SYMS   = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  Send,
  input  logic [3*NUM_SYMS-1:0] Code,
  input  logic                  U,
`ifdef SWEEP_EN
  input  logic                  Sweep,
  output logic                  Found,
  output logic [3*NUM_SYMS-1:0] Found_code,
`endif
  output logic                  Start,
  output logic                  Red,
  output logic                  Green,
  output logic                  Blue,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Match
);

  localparam int CW = 3 * NUM_SYMS;
  localparam int SW = (NUM_SYMS > 1) ? $clog2(NUM_SYMS) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(NUM_SYMS - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SYM,
    S_CHECK,
    S_GAP
  } state_t;

  state_t        state_q;
  logic [SW-1:0] sym_q;
  logic [GW-1:0] gap_q;
  // Latched code, shifted down 3 bits per symbol so the next symbol is always at [2:0].
  logic [CW-1:0] code_sh_q;
  logic          start_q;
  logic [2:0]    rgb_q;
  logic          busy_q;
  logic          done_q;
  logic          match_q;

`ifdef SWEEP_EN
  logic          sweeping_q;
  logic [CW-1:0] sweep_code_q;
  logic          found_q;
  logic [CW-1:0] found_code_q;
`endif

  // Frame sequencer; every output is a register, written when its state is entered.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= S_IDLE;
      sym_q        <= '0;
      gap_q        <= '0;
      code_sh_q    <= '0;
      start_q      <= 1'b0;
      rgb_q        <= 3'b000;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      match_q      <= 1'b0;
`ifdef SWEEP_EN
      sweeping_q   <= 1'b0;
      sweep_code_q <= '0;
      found_q      <= 1'b0;
      found_code_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          start_q <= 1'b0;
          rgb_q   <= 3'b000;
          busy_q  <= 1'b0;
`ifdef SWEEP_EN
          // Sweep has priority over a simultaneous Send.
          if (Sweep) begin
            state_q      <= S_HDR;
            code_sh_q    <= '0;
            sweep_code_q <= '0;
            sweeping_q   <= 1'b1;
            found_q      <= 1'b0;
            found_code_q <= '0;
            start_q      <= 1'b1;
            busy_q       <= 1'b1;
          end else if (Send) begin
            state_q   <= S_HDR;
            code_sh_q <= Code;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
`else
          if (Send) begin
            state_q   <= S_HDR;
            code_sh_q <= Code;
            start_q   <= 1'b1;
            busy_q    <= 1'b1;
          end
`endif
        end

        S_HDR: begin
          state_q   <= S_SYM;
          sym_q     <= '0;
          rgb_q     <= code_sh_q[2:0];
          code_sh_q <= code_sh_q >> 3;
        end

        S_SYM: begin
          if (sym_q == SYM_LAST) begin
            state_q <= S_CHECK;
            rgb_q   <= 3'b000;
          end else begin
            sym_q     <= sym_q + SW'(1);
            rgb_q     <= code_sh_q[2:0];
            code_sh_q <= code_sh_q >> 3;
          end
        end

        S_CHECK: begin
          state_q <= S_GAP;
          start_q <= 1'b0;
          done_q  <= 1'b1;
          match_q <= U;
          gap_q   <= GAP_LOAD;
`ifdef SWEEP_EN
          // Later matches overwrite earlier ones.
          if (sweeping_q && U) begin
            found_q      <= 1'b1;
            found_code_q <= sweep_code_q;
          end
`endif
        end

        S_GAP: begin
          if (gap_q == '0) begin
            sym_q <= '0;
`ifdef SWEEP_EN
            // Chain straight into the next code's header so Busy never drops mid-sweep.
            if (sweeping_q && (sweep_code_q != '1)) begin
              state_q      <= S_HDR;
              sweep_code_q <= sweep_code_q + CW'(1);
              code_sh_q    <= sweep_code_q + CW'(1);
              start_q      <= 1'b1;
            end else begin
              state_q    <= S_IDLE;
              sweeping_q <= 1'b0;
              busy_q     <= 1'b0;
            end
`else
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
`endif
          end else begin
            gap_q <= gap_q - GW'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          start_q <= 1'b0;
          rgb_q   <= 3'b000;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Start = start_q;
  assign Red   = rgb_q[2];
  assign Green = rgb_q[1];
  assign Blue  = rgb_q[0];
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Match = match_q;

`ifdef SWEEP_EN
  assign Found      = found_q;
  assign Found_code = found_code_q;
`endif

endmodule
